seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6: number of scanned digits, legal range 1..8.
REQ-002 SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit slot, legal range >= GUARD+2.
REQ-003 SHALL have parameter GUARD, default 2: blanking cycles at the start of each slot (anti-ghosting), legal range 0..SCAN_DIV-2.
REQ-004 SHALL have parameter BLINK_FRAMES, default 64: full scan frames per blink half-period, legal range >= 1.
REQ-005 SHALL have parameter POS_ACTIVE_LOW, default 1: polarity of the pos outputs.
REQ-006 SHALL have one clock; reset is asynchronous and active-low. Ports: clk, cr.
REQ-007 clk  input  1  system clock; all state on rising edge.
REQ-008 cr  input  1  asynchronous active-low clear.
REQ-009 en  input  1  scan enable; when low, counters hold and the display is dark.
REQ-010 bcd  input  4*NUM_DIGITS  digit values; digit i is bcd[4i+3:4i], and digit 0 is rightmost.
REQ-011 dp  input  NUM_DIGITS  decimal-point request per digit.
REQ-012 blink  input  NUM_DIGITS  blink request per digit.
REQ-013 blank_lz  input  1  leading-zero blanking enable.
REQ-014 seg  output  7  segments a..g in seg[0]..seg[6], active-high, registered.
REQ-015 dp_out  output  1  decimal point, active-high, registered.
REQ-016 pos  output  8  digit select, one-hot in POS_ACTIVE_LOW polarity, registered.
REQ-017 frame_tick  output  1  one-cycle pulse when the digit index wraps to 0.

Function
REQ-018 Slot counter: SHALL count 0..SCAN_DIV-1 while en=1 and wrap to 0; the digit index SHALL advance at each wrap, running 0..NUM_DIGITS-1 and then back to 0.
REQ-019 Shadow register: SHALL capture bcd, dp and blink in the cycle the index wraps to 0, and at reset release; a digit never changes mid-frame (no tearing).
REQ-020 Output latency: seg, dp_out and pos SHALL reflect the index and slot count of cycle t at cycle t+1.
REQ-021 Guard: during slot counts 0..GUARD-1, pos SHALL be all-inactive and seg/dp_out SHALL be 0.
REQ-022 Outside guard, exactly one pos bit (the current index) SHALL be active; bits >= NUM_DIGITS SHALL stay inactive.
REQ-023 Decode: values 0..9 SHALL produce the standard patterns; values 10..15 SHALL produce a dash (seg[6] only).
REQ-024 Leading-zero blanking, when blank_lz=1: a digit SHALL be blanked (seg=0, dp_out=0) if it and all higher-index digits are 0 with dp=0; digit 0 SHALL never be blanked.
REQ-025 Blink: a phase bit SHALL toggle every BLINK_FRAMES frames; while the phase is 1, digits with blink=1 SHALL be blanked (seg=0, dp_out=0) while pos still scans.
REQ-026 frame_tick SHALL assert for exactly one cycle, in the cycle the index changes from NUM_DIGITS-1 to 0.
REQ-027 en=0: slot counter, index, blink counter and shadow SHALL hold; from the next cycle pos SHALL be inactive and seg=0, dp_out=0, frame_tick=0. When en returns to 1, scanning SHALL resume from the held state.
REQ-028 NUM_DIGITS=1: the index SHALL stay 0, and frame_tick SHALL pulse at every slot wrap.

Reset
REQ-029 cr=0 SHALL asynchronously clear the slot counter, index, blink counter, phase and shadow to 0.
REQ-030 During reset: seg=0, dp_out=0, frame_tick=0, and pos all-inactive (8'hFF when POS_ACTIVE_LOW=1, 8'h00 otherwise).
REQ-031 Reset asserted mid-slot or mid-frame SHALL take effect immediately; after release the first slot SHALL be digit 0 at count 0, guard included.

Structure
REQ-032 Package seg_scan_pkg SHALL hold the segment pattern constants (digits 0..9, dash, blank) and the index-width function clog2.
REQ-033 Sub-module seg7_decode (combinational: 4-bit value -> 7 segments) SHALL be instantiated once; all counters and output registers SHALL live in seg_scan_driver.

Verification
REQ-034 Bench parameters: NUM_DIGITS=4, SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2.
- Scan: bcd=16'h4321 -> pos sequence E,E (guard FF first) per slot, cycling FE,FD,FB,F7; seg=0x06,0x5B,0x4F,0x66; frame_tick every 16 cycles.
- Leading-zero blanking: bcd=16'h0070 with blank_lz=1 -> digits 3 and 2 give seg=0, digit 1 gives 0x07, digit 0 gives 0x3F; with blank_lz=0, digits 3 and 2 give 0x3F.
- Tearing: change bcd mid-frame -> the new value appears only after the next frame_tick.
- Blink: blink=4'b0001 -> digit 0 is blanked in frames 2-3, lit in frames 0-1 and 4-5; pos keeps scanning.
- en and reset: drop en in slot 2 for 10 cycles -> pos=FF, resume at the same slot count; assert cr mid-slot -> pos=FF and seg=0 immediately, restart at digit 0 with a guard cycle.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Segment patterns and width helper shared by the multiplexed 7-segment scanner.
package seg_scan_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int p = 1; p < value; p = p * 2) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decode (a..g in bit 0..6); non-decimal values show a dash.
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (val)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scanner with guard blanking, leading-zero blanking and blink.
// Outputs are registered: seg/dp_out/pos at cycle t+1 reflect index and slot count of cycle t.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD          = 2,
  parameter int BLINK_FRAMES   = 64,
  parameter bit POS_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    cr,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] bcd,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp_out,
  output logic [7:0]              pos,
  output logic                    frame_tick
);

  localparam int IDX_W = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS);
  localparam int CNT_W = (clog2(SCAN_DIV) < 1) ? 1 : clog2(SCAN_DIV);
  localparam int BLK_W = (clog2(BLINK_FRAMES) < 1) ? 1 : clog2(BLINK_FRAMES);
  localparam logic [7:0] POS_OFF = POS_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [CNT_W-1:0]        slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLK_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                    phase_q, phase_d;
  logic [4*NUM_DIGITS-1:0] bcd_sh_q, bcd_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]   blink_sh_q, blink_sh_d;
  logic                    load_pend_q, load_pend_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_out_q, dp_out_d;
  logic [7:0]              pos_q, pos_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    slot_wrap, frame_wrap, guard;
  logic [4*NUM_DIGITS-1:0] bcd_eff;
  logic [NUM_DIGITS-1:0]   dp_eff, blink_eff, lz_vec;
  logic                    lz_run, dp_cur, blink_cur, lz_cur, dark;
  logic [3:0]              digit;
  logic [6:0]              seg_dec;
  logic [7:0]              onehot;

  assign slot_wrap  = (slot_cnt_q == CNT_W'(SCAN_DIV - 1));
  assign frame_wrap = slot_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign guard      = (int'(slot_cnt_q) < GUARD);

  // Right after reset the shadow is not loaded yet, so look through to the live inputs.
  assign bcd_eff   = load_pend_q ? bcd   : bcd_sh_q;
  assign dp_eff    = load_pend_q ? dp    : dp_sh_q;
  assign blink_eff = load_pend_q ? blink : blink_sh_q;

  always_comb begin
    slot_cnt_d   = slot_cnt_q;
    idx_d        = idx_q;
    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;
    bcd_sh_d     = bcd_sh_q;
    dp_sh_d      = dp_sh_q;
    blink_sh_d   = blink_sh_q;
    load_pend_d  = 1'b0;
    frame_tick_d = en && frame_wrap;
    if (en) begin
      slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + CNT_W'(1);
      if (slot_wrap) idx_d = frame_wrap ? '0 : idx_q + IDX_W'(1);
      if (frame_wrap) begin
        bcd_sh_d   = bcd;
        dp_sh_d    = dp;
        blink_sh_d = blink;
        if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BLK_W'(1);
        end
      end
    end
    if (load_pend_q) begin
      bcd_sh_d   = bcd;
      dp_sh_d    = dp;
      blink_sh_d = blink;
    end
  end

  // A digit is a leading zero when it and every higher digit are 0 without a decimal point.
  always_comb begin
    lz_vec = '0;
    lz_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run    = lz_run & (bcd_eff[4*i +: 4] == 4'd0) & ~dp_eff[i];
      lz_vec[i] = lz_run & (i != 0);
    end
  end

  always_comb begin
    digit     = 4'd0;
    dp_cur    = 1'b0;
    blink_cur = 1'b0;
    lz_cur    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        digit     = bcd_eff[4*i +: 4];
        dp_cur    = dp_eff[i];
        blink_cur = blink_eff[i];
        lz_cur    = lz_vec[i];
      end
    end
  end

  seg7_decode u_decode (
    .val (digit),
    .seg (seg_dec)
  );

  always_comb begin
    onehot   = 8'd1 << idx_q;
    dark     = (blank_lz && lz_cur) || (phase_q && blink_cur);
    seg_d    = SEG_BLANK;
    dp_out_d = 1'b0;
    pos_d    = POS_OFF;
    if (en && !guard) begin
      pos_d = POS_ACTIVE_LOW ? ~onehot : onehot;
      if (!dark) begin
        seg_d    = seg_dec;
        dp_out_d = dp_cur;
      end
    end
  end

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      slot_cnt_q   <= '0;
      idx_q        <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      bcd_sh_q     <= '0;
      dp_sh_q      <= '0;
      blink_sh_q   <= '0;
      load_pend_q  <= 1'b1;
      seg_q        <= SEG_BLANK;
      dp_out_q     <= 1'b0;
      pos_q        <= POS_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      bcd_sh_q     <= bcd_sh_d;
      dp_sh_q      <= dp_sh_d;
      blink_sh_q   <= blink_sh_d;
      load_pend_q  <= load_pend_d;
      seg_q        <= seg_d;
      dp_out_q     <= dp_out_d;
      pos_q        <= pos_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp_out     = dp_out_q;
  assign pos        = pos_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4 digits, 4-cycle slots, 1 guard cycle, 2-frame blink.
module tb_seg_scan_driver;

  logic        clk;
  logic        cr;
  logic        en;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic [3:0]  blink;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp_out;
  logic [7:0]  pos;
  logic        frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  seg_scan_driver #(
    .NUM_DIGITS     (4),
    .SCAN_DIV       (4),
    .GUARD          (1),
    .BLINK_FRAMES   (2),
    .POS_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .cr         (cr),
    .en         (en),
    .bcd        (bcd),
    .dp         (dp),
    .blink      (blink),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp_out     (dp_out),
    .pos        (pos),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    cr = 1'b0;
    #1;
    check_val({tag, " rst pos"}, 32'(pos), 32'hFF);
    check_val({tag, " rst seg"}, 32'(seg), 32'h00);
    check_val({tag, " rst dp_out"}, 32'(dp_out), 32'h0);
    check_val({tag, " rst tick"}, 32'(frame_tick), 32'h0);
    repeat (2) @(negedge clk);
    cr = 1'b1;
  endtask

  // Runs one 16-cycle frame from its first edge; e0..e3 are lit patterns for digits 0..3.
  task automatic frame_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3, input logic [3:0] edp,
                             input int chg_k, input logic [15:0] chg_val);
    logic [6:0] segs [4];
    logic [7:0] exp_pos;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int         s, d;
    segs[0] = e0; segs[1] = e1; segs[2] = e2; segs[3] = e3;
    for (int k = 0; k < 16; k++) begin
      step();
      s = k % 4;
      d = k / 4;
      exp_pos = 8'h01 << d;
      exp_pos = (s == 0) ? 8'hFF : ~exp_pos;
      exp_seg = (s == 0) ? 7'h00 : segs[d];
      exp_dp  = (s == 0) ? 1'b0 : edp[d];
      check_val($sformatf("%s pos k%0d", tag, k), 32'(pos), 32'(exp_pos));
      check_val($sformatf("%s seg k%0d", tag, k), 32'(seg), 32'(exp_seg));
      check_val($sformatf("%s dp k%0d", tag, k), 32'(dp_out), 32'(exp_dp));
      check_val($sformatf("%s tick k%0d", tag, k), 32'(frame_tick), (k == 15) ? 32'h1 : 32'h0);
      if (k == chg_k) bcd = chg_val;
    end
  endtask

  initial begin
    cr = 1'b0; en = 1'b1; bcd = 16'h4321; dp = 4'h0; blink = 4'h0; blank_lz = 1'b0;
    @(negedge clk);

    // Plain scan of 4321, two consecutive frames
    do_reset("scan");
    frame_check("scan f0", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'h0, -1, 16'h0);
    frame_check("scan f1", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'h0, -1, 16'h0);

    // Decode of 8, 9 and non-decimal dashes
    bcd = 16'hFA98;
    do_reset("dec");
    frame_check("dec", 7'h7F, 7'h6F, 7'h40, 7'h40, 4'h0, -1, 16'h0);

    // Leading-zero blanking on, then off (blank_lz is not shadowed)
    bcd = 16'h0070; blank_lz = 1'b1;
    do_reset("lz");
    frame_check("lz on", 7'h3F, 7'h07, 7'h00, 7'h00, 4'h0, -1, 16'h0);
    blank_lz = 1'b0;
    frame_check("lz off", 7'h3F, 7'h07, 7'h3F, 7'h3F, 4'h0, -1, 16'h0);

    // All zeros: digit 0 always lit; a decimal point on digit 2 stops blanking below it
    bcd = 16'h0000; dp = 4'b0100; blank_lz = 1'b1;
    do_reset("lzdp");
    frame_check("lz dp", 7'h3F, 7'h3F, 7'h3F, 7'h00, 4'b0100, -1, 16'h0);
    dp = 4'h0; blank_lz = 1'b0;

    // Tearing: bcd changed while digit 1 is shown; new value only from next frame
    bcd = 16'h4321;
    do_reset("tear");
    frame_check("tear f0", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'h0, 5, 16'h8765);
    frame_check("tear f1", 7'h6D, 7'h7D, 7'h07, 7'h7F, 4'h0, -1, 16'h0);

    // Blink digit 0: lit frames 0-1, dark 2-3, lit 4
    bcd = 16'h4321; blink = 4'b0001;
    do_reset("blink");
    frame_check("blink f0", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'h0, -1, 16'h0);
    frame_check("blink f1", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'h0, -1, 16'h0);
    frame_check("blink f2", 7'h00, 7'h5B, 7'h4F, 7'h66, 4'h0, -1, 16'h0);
    frame_check("blink f3", 7'h00, 7'h5B, 7'h4F, 7'h66, 4'h0, -1, 16'h0);
    frame_check("blink f4", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'h0, -1, 16'h0);
    blink = 4'h0;

    // en low during digit 2 slot (count 2 held), then resume
    do_reset("en");
    repeat (10) step();
    check_val("en pre pos", 32'(pos), 32'hFB);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check_val($sformatf("en off pos %0d", k), 32'(pos), 32'hFF);
      check_val($sformatf("en off seg %0d", k), 32'(seg), 32'h00);
      check_val($sformatf("en off tick %0d", k), 32'(frame_tick), 32'h0);
    end
    en = 1'b1;
    step(); check_val("en res pos0", 32'(pos), 32'hFB); check_val("en res seg0", 32'(seg), 32'h4F);
    step(); check_val("en res pos1", 32'(pos), 32'hFB);
    step(); check_val("en res pos2", 32'(pos), 32'hFF);
    step(); check_val("en res pos3", 32'(pos), 32'hF7); check_val("en res seg3", 32'(seg), 32'h66);

    // Asynchronous clear mid-slot takes effect before the next edge
    #2 cr = 1'b0;
    #1;
    check_val("cr mid pos", 32'(pos), 32'hFF);
    check_val("cr mid seg", 32'(seg), 32'h00);
    @(negedge clk);
    do_reset("cr");
    frame_check("cr restart", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'h0, -1, 16'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
